lamp_seq_monitor: RTL and testbench
===================================

# lamp_seq_monitor

Receive-side checker for the three-lamp cyclic controller. Samples the 3-bit one-hot lamp bus and tracks the legal RED → GREEN → YELLOW → RED sequence. Flags illegal codes, out-of-order steps and stuck lamps, and counts completed cycles. Sits beside the lamp controller on the same clock, as a watchdog whose `fault` output drives a supervisor or safe-state override.

## Interface
- `MAX_DWELL`, default 16: maximum consecutive cycles one colour may be held before the lamp counts as stuck; legal range 1–255.
- `CNT_W`, default 8: width of the completed-cycle counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `light`  in  [0:2]  lamp bus; RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- `clr_fault`  in  1  synchronous request to clear a latched fault and resynchronise.
- `cur_color`  out  2  last legal colour tracked: 0=RED, 1=GREEN, 2=YELLOW, 3=none.
- `in_sync`  out  1  monitor is locked to the sequence.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  0=none, 1=illegal code, 2=order violation, 3=stuck.
- `cycle_count`  out  CNT_W  number of completed YELLOW→RED transitions; wraps to 0.

## Operation
- Input stage: `light` is registered into `light_q` every cycle. The FSM evaluates only `light_q`.
- FSM states: SYNC, RED, GREEN, YELLOW, FAULT. Reset state is SYNC.
- SYNC:
  - `light_q`=RED → RED state, dwell counter set to 1.
  - GREEN or YELLOW → stay in SYNC, no fault.
  - Illegal code → FAULT.
- RED / GREEN / YELLOW, on a legal code:
  - Same colour → stay; dwell counter increments (saturating at 255).
  - Next colour in sequence → advance; dwell counter set to 1.
  - YELLOW→RED additionally increments `cycle_count`, modulo 2^CNT_W.
  - Any other colour → FAULT with code 2.
- Illegal code: any value not exactly one-hot (000, 011, 101, 110, 111) → FAULT with code 1, from any non-FAULT state.
- Stuck: if the dwell counter would exceed `MAX_DWELL` → FAULT with code 3.
- Fault priority when several conditions hold in one cycle: illegal, then order, then stuck.
- FAULT:
  - `fault_code` and `cur_color` are frozen; `light_q` is ignored.
  - `clr_fault`=1 → SYNC, `fault`=0, `fault_code`=0, `cur_color`=3.
  - `cycle_count` is never cleared by `clr_fault`.
- `clr_fault` outside FAULT has no effect. A new fault detected in the same cycle as a `clr_fault` outside FAULT is latched.
- `in_sync`=1 exactly in RED, GREEN and YELLOW.

## Timing
- Reset values: `light_q`=3'b000, state=SYNC, dwell=0, `cur_color`=3, `in_sync`=0, `fault`=0, `fault_code`=0, `cycle_count`=0.
- Reset is asynchronous: all outputs take their reset values immediately on `rst_n` falling. Reset is released synchronously through a two-flop deassertion synchroniser inside the block.
- Latency: a value on `light` at edge k is in `light_q` after edge k; resulting FSM/output changes are visible after edge k+1. That is two edges from input to `fault`.
- The controller's normal 1-cycle-per-colour stepping gives dwell=1 and never trips stuck when `MAX_DWELL`≥1.
- Reset mid-sequence: the monitor re-enters SYNC and ignores GREEN/YELLOW until the next RED.
- `cycle_count` wraps from 2^CNT_W−1 to 0 without a flag.

## Structure
- Shared `lamp_pkg` holds:
  - colour codes (RED/GREEN/YELLOW 3-bit constants);
  - the colour index enum used by `cur_color`;
  - the FSM state enum;
  - the fault-code enum.
- The same package is reused by the lamp controller.
- One sub-module: `lamp_dwell_counter`, a saturating 8-bit counter with load-1 and increment controls and a `over_max` compare against `MAX_DWELL`.
- Everything else lives in the top module.

## Test plan
- Legal sequence: reset, then drive RED,GREEN,YELLOW repeatedly for 10 cycles of the sequence → `fault`=0, `in_sync`=1 from 2 edges after the first RED, `cycle_count`=10 (or 9 if the last YELLOW→RED has not occurred).
- Illegal code: mid-sequence, drive 3'b110 for one cycle → `fault`=1, `fault_code`=1 two edges later. Then `clr_fault` pulse → `fault`=0, state SYNC, `cycle_count` unchanged.
- Order violation: RED then YELLOW → `fault_code`=2. Start-up on GREEN,YELLOW,RED → no fault, lock on RED.
- Stuck: with `MAX_DWELL`=4, hold GREEN 5 cycles → `fault_code`=3 on the 5th sample. Hold GREEN exactly 4 cycles then YELLOW → no fault.
- Wrap and reset: with `CNT_W`=2, 4 full cycles → `cycle_count`=0. Assert `rst_n`=0 mid-GREEN → all outputs at reset values immediately; after release, GREEN is ignored until RED.
- Priority and simultaneity: with `MAX_DWELL` reached, present 3'b111 → `fault_code`=1. In FAULT, hold `clr_fault`=1 while driving an illegal code → one cycle in SYNC, then FAULT with code 1.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared definitions for the three-lamp cyclic controller and its monitor.
// Lamp codes, colour/state/fault enums and small decode helpers.
package lamp_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_GREEN  = 2'd1,
        COL_YELLOW = 2'd2,
        COL_NONE   = 2'd3
    } colour_e;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_ILLEGAL = 2'd1,
        FLT_ORDER   = 2'd2,
        FLT_STUCK   = 2'd3
    } fault_e;

    function automatic logic is_onehot(input logic [2:0] code);
        return (code == LAMP_RED)
            || (code == LAMP_GREEN)
            || (code == LAMP_YELLOW);
    endfunction

    function automatic colour_e decode(input logic [2:0] code);
        colour_e c;
        case (code)
            LAMP_RED:    c = COL_RED;
            LAMP_GREEN:  c = COL_GREEN;
            LAMP_YELLOW: c = COL_YELLOW;
            default:     c = COL_NONE;
        endcase
        return c;
    endfunction

    function automatic colour_e next_colour(input colour_e c);
        colour_e n;
        case (c)
            COL_RED:    n = COL_GREEN;
            COL_GREEN:  n = COL_YELLOW;
            default:    n = COL_RED;
        endcase
        return n;
    endfunction

    function automatic state_e colour_state(input colour_e c);
        state_e s;
        case (c)
            COL_RED:    s = ST_RED;
            COL_GREEN:  s = ST_GREEN;
            COL_YELLOW: s = ST_YELLOW;
            default:    s = ST_SYNC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// Saturating 8-bit dwell counter with clear, load-1 and increment.
// over_max flags that the next increment would pass MAX_DWELL.
module lamp_dwell_counter
    import lamp_pkg::*;
#(
    parameter int MAX_DWELL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic over_max
);

    localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0] SAT   = '1;

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] count_inc;

    assign count_inc = (count == SAT)
                     ? count
                     : count + DWELL_W'(1);

    assign over_max = (count_inc > LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= DWELL_W'(1);
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/lamp_seq_monitor.sv
// Receive-side watchdog for the RED->GREEN->YELLOW lamp sequence.
// Flags illegal codes, order violations and stuck lamps; counts cycles.
module lamp_seq_monitor
    import lamp_pkg::*;
#(
    parameter int MAX_DWELL = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:2]       light,
    input  logic             clr_fault,
    output logic [1:0]       cur_color,
    output logic             in_sync,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count
);

    logic [1:0] rst_meta;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 2'b00;
        end else begin
            rst_meta <= {rst_meta[0], 1'b1};
        end
    end

    assign rst_int_n = rst_meta[1];

    logic [0:2] light_q;
    logic       q_valid;

    // q_valid keeps the reset value of light_q from being judged as a sample
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            light_q <= 3'b000;
            q_valid <= 1'b0;
        end else begin
            light_q <= light;
            q_valid <= 1'b1;
        end
    end

    logic    legal;
    colour_e samp_col;

    assign legal    = is_onehot(light_q);
    assign samp_col = decode(light_q);

    state_e  state_q, state_d;
    colour_e col_q, col_d;
    fault_e  code_q, code_d;
    logic    dw_clr, dw_load, dw_inc;
    logic    over_max;
    logic    cyc_inc;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        code_d  = code_q;
        dw_clr  = 1'b0;
        dw_load = 1'b0;
        dw_inc  = 1'b0;
        cyc_inc = 1'b0;
        unique case (state_q)
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d = ST_SYNC;
                    col_d   = COL_NONE;
                    code_d  = FLT_NONE;
                    dw_clr  = 1'b1;
                end
            end
            ST_SYNC: begin
                if (q_valid) begin
                    unique case (1'b1)
                        !legal: begin
                            state_d = ST_FAULT;
                            code_d  = FLT_ILLEGAL;
                        end
                        (samp_col == COL_RED): begin
                            state_d = ST_RED;
                            col_d   = COL_RED;
                            dw_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (q_valid) begin
                    unique case (1'b1)
                        !legal: begin
                            state_d = ST_FAULT;
                            code_d  = FLT_ILLEGAL;
                        end
                        (samp_col == col_q): begin
                            if (over_max) begin
                                state_d = ST_FAULT;
                                code_d  = FLT_STUCK;
                            end else begin
                                dw_inc = 1'b1;
                            end
                        end
                        (samp_col == next_colour(col_q)): begin
                            state_d = colour_state(samp_col);
                            col_d   = samp_col;
                            dw_load = 1'b1;
                            cyc_inc = (col_q == COL_YELLOW);
                        end
                        default: begin
                            state_d = ST_FAULT;
                            code_d  = FLT_ORDER;
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        in_sync = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            ST_RED, ST_GREEN, ST_YELLOW: in_sync = 1'b1;
            ST_FAULT:                    fault   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            col_q  <= COL_NONE;
            code_q <= FLT_NONE;
        end else begin
            col_q  <= col_d;
            code_q <= code_d;
        end
    end

    logic [CNT_W-1:0] cnt_q;

    // Wraps silently; never cleared by clr_fault
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_q <= '0;
        end else if (cyc_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    lamp_dwell_counter #(
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .clr      (dw_clr),
        .load     (dw_load),
        .inc      (dw_inc),
        .over_max (over_max)
    );

    assign cur_color   = col_q;
    assign fault_code  = code_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Directed bench for lamp_seq_monitor against a sequence-rule model.
// Small MAX_DWELL and CNT_W so stuck and wrap cases stay short.
module tb_lamp_seq_monitor;

    localparam int MAXD = 4;
    localparam int CW   = 2;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic          clk;
    logic          rst_n;
    logic [0:2]    light;
    logic          clr_fault;
    logic [1:0]    cur_color;
    logic          in_sync;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] cycle_count;

    lamp_seq_monitor #(
        .MAX_DWELL (MAXD),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light       (light),
        .clr_fault   (clr_fault),
        .cur_color   (cur_color),
        .in_sync     (in_sync),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: judges each registered sample one edge later
    int       m_col, m_code, m_count, m_run, m_wait;
    bit       m_locked, m_fault, m_have, m_rst;
    logic [2:0] m_samp;

    task automatic model_reset();
        m_col = 3; m_code = 0; m_count = 0; m_run = 0;
        m_locked = 0; m_fault = 0; m_have = 0;
        m_rst = 1; m_wait = 0; m_samp = 3'b000;
    endtask

    task automatic model_eval(input logic c);
        int idx;
        if (m_fault) begin
            if (c) begin
                m_fault = 0; m_code = 0; m_col = 3;
                m_locked = 0; m_run = 0;
            end
            return;
        end
        if ($countones(m_samp) != 1) begin
            m_fault = 1; m_code = 1;
            return;
        end
        idx = m_samp[2] ? 0 : (m_samp[1] ? 1 : 2);
        if (!m_locked) begin
            if (idx == 0) begin
                m_locked = 1; m_col = 0; m_run = 1;
            end
            return;
        end
        if (idx == m_col) begin
            if (m_run + 1 > MAXD) begin
                m_fault = 1; m_code = 3;
            end else begin
                m_run++;
            end
        end else if (idx == (m_col + 1) % 3) begin
            if (m_col == 2) m_count = (m_count + 1) % (1 << CW);
            m_col = idx;
            m_run = 1;
        end else begin
            m_fault = 1; m_code = 2;
        end
    endtask

    task automatic model_step(input logic [2:0] lt, input logic c);
        if (m_rst) return;
        if (m_wait > 0) begin
            m_wait--;
            return;
        end
        if (m_have) model_eval(c);
        m_samp = lt;
        m_have = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cur_color", int'(cur_color), m_col);
                check("in_sync", int'(in_sync), int'(m_locked && !m_fault));
                check("fault", int'(fault), int'(m_fault));
                check("fault_code", int'(fault_code), m_code);
                check("cycle_count", int'(cycle_count), m_count);
            end
        end
    end

    task automatic cyc(input logic [2:0] lt, input logic c);
        light = lt;
        clr_fault = c;
        @(posedge clk);
        model_step(lt, c);
        #2;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        m_rst = 0;
        m_wait = 2;
    endtask

    initial begin
        rst_n = 1'b0;
        light = R;
        clr_fault = 1'b0;
        model_reset();
        cyc(R, 0);
        chk_en = 1'b1;
        cyc(R, 0);
        check("rst_cur_color", int'(cur_color), 3);
        check("rst_fault", int'(fault), 0);
        check("rst_in_sync", int'(in_sync), 0);
        check("rst_count", int'(cycle_count), 0);

        // legal sequence, 10 full cycles
        release_reset();
        repeat (3) cyc(R, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(G, 0); cyc(Y, 0); cyc(R, 0);
        end
        cyc(R, 0);
        check("legal_count", int'(cycle_count), 2);
        check("legal_in_sync", int'(in_sync), 1);
        check("legal_fault", int'(fault), 0);

        // illegal code mid-sequence, then clear
        cyc(G, 0); cyc(3'b110, 0); cyc(G, 0);
        check("illegal_fault", int'(fault), 1);
        check("illegal_code", int'(fault_code), 1);
        check("illegal_col", int'(cur_color), 1);
        cyc(G, 1);
        check("clr_fault", int'(fault), 0);
        check("clr_col", int'(cur_color), 3);
        check("clr_count", int'(cycle_count), 2);

        // order violation RED -> YELLOW
        cyc(R, 0); cyc(Y, 0); cyc(R, 0);
        check("order_code", int'(fault_code), 2);
        check("order_col", int'(cur_color), 0);
        cyc(G, 1);

        // start-up on GREEN, YELLOW, RED locks on RED
        cyc(Y, 0); cyc(R, 0); cyc(G, 0);
        check("startup_in_sync", int'(in_sync), 1);
        check("startup_col", int'(cur_color), 0);

        // GREEN held for 5 samples trips stuck
        repeat (5) cyc(G, 0);
        check("stuck_code", int'(fault_code), 3);
        check("stuck_col", int'(cur_color), 1);

        // GREEN held exactly MAXD samples is fine
        cyc(R, 1);
        repeat (4) cyc(G, 0);
        cyc(Y, 0); cyc(R, 0);
        check("dwell_ok_fault", int'(fault), 0);
        check("dwell_ok_col", int'(cur_color), 2);

        // dwell at limit, then 111 reports illegal
        repeat (3) cyc(R, 0);
        cyc(3'b111, 0); cyc(R, 0);
        check("prio_code", int'(fault_code), 1);
        check("prio_count", int'(cycle_count), 3);

        // clr held while an illegal code arrives
        cyc(3'b011, 1);
        check("simul_sync_fault", int'(fault), 0);
        cyc(R, 1);
        check("simul_refault", int'(fault), 1);
        check("simul_code", int'(fault_code), 1);

        // counter wrap 3 -> 0
        cyc(R, 1);
        cyc(G, 0); cyc(Y, 0); cyc(R, 0); cyc(G, 0);
        check("wrap_count", int'(cycle_count), 0);
        check("wrap_col", int'(cur_color), 0);

        // async reset mid-GREEN
        cyc(G, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_col", int'(cur_color), 3);
        check("async_in_sync", int'(in_sync), 0);
        check("async_fault", int'(fault), 0);
        check("async_code", int'(fault_code), 0);
        check("async_count", int'(cycle_count), 0);
        cyc(G, 0); cyc(G, 0);
        release_reset();
        repeat (4) cyc(G, 0);
        check("post_rst_ignore", int'(in_sync), 0);
        check("post_rst_fault", int'(fault), 0);
        cyc(R, 0); cyc(G, 0);
        check("post_rst_lock", int'(in_sync), 1);
        cyc(G, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
